// File: rtl/fpga_config_loader.sv
// ---------------------------------------------------------------------------
// fpga_config_loader
//
// Purpose:
//   Loads configuration frames into a fabric of NUM_ROWS x NUM_COLS tiles.
//   The bitstream arrives SHIFT_WIDTH bits per beat and is shifted into a
//   FRAME_W-bit frame register. Once a frame is complete, the matching
//   one-hot frame write strobe is pulsed for STROBE_LEN cycles.
//
//   Two modes are supported:
//   - Auto: a start pulse streams every frame in order, beginning at frame 0.
//   - Manual: legacy software control of shifting, address and strobe.
//
// Ports:
//   config_clk      sole clock, rising edge
//   config_rst_n    synchronous active-low reset
//   mode_auto       1 = auto streaming load, 0 = manual control
//   start           auto mode: begin a full load from frame 0
//   din/din_valid   bitstream beat and its valid flag
//   din_ready       beat accepted when din_valid & din_ready
//   man_shift       manual: shift din into the frame register
//   man_addr_reset  manual: clear frame address (wins over increment)
//   man_addr_incr   manual: increment frame address (wraps)
//   man_strobe      manual: pulse strobe of current frame, one cycle later
//   frame_data      frame data register
//   frame_strobe    registered one-hot frame write strobes
//   frame_addr      current frame address
//   busy/done       auto load in progress / auto load finished
//   overrun         sticky: data offered while no load was running
// ---------------------------------------------------------------------------
module fpga_config_loader #(
    parameter int NUM_ROWS           = 3,
    parameter int NUM_COLS           = 6,
    parameter int FRAME_BITS_PER_ROW = 32,
    parameter int MAX_FRAMES_PER_COL = 36,
    parameter int SHIFT_WIDTH        = 8,
    parameter int STROBE_LEN         = 2,
    localparam int FRAME_W           = NUM_ROWS * FRAME_BITS_PER_ROW,
    localparam int NUM_FRAMES        = NUM_COLS * MAX_FRAMES_PER_COL,
    localparam int BEATS             = FRAME_W / SHIFT_WIDTH,
    localparam int ADDR_W            = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                   config_clk,
    input  logic                   config_rst_n,
    input  logic                   mode_auto,
    input  logic                   start,
    input  logic [SHIFT_WIDTH-1:0] din,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic                   man_shift,
    input  logic                   man_addr_reset,
    input  logic                   man_addr_incr,
    input  logic                   man_strobe,
    output logic [FRAME_W-1:0]     frame_data,
    output logic [NUM_FRAMES-1:0]  frame_strobe,
    output logic [ADDR_W-1:0]      frame_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TIMER_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_STROBE,
        ST_GAP,
        ST_DONE
    } loaderState_t;

    loaderState_t r_state;
    loaderState_t w_nextState;

    logic [FRAME_W-1:0]    r_frameData;
    logic [NUM_FRAMES-1:0] r_frameStrobe;
    logic [ADDR_W-1:0]     r_frameAddr;
    logic [BEAT_W-1:0]     r_beatCount;
    logic [TIMER_W-1:0]    r_strobeTimer;
    logic                  r_overrun;

    logic                  w_accept;
    logic                  w_lastBeat;
    logic                  w_strobeEnd;
    logic                  w_lastFrame;
    logic                  w_idleOrDone;
    logic                  w_startLoad;
    logic                  w_manual;
    logic                  w_addrInRange;
    logic [NUM_FRAMES-1:0] w_addrOneHot;
    logic [FRAME_W-1:0]    w_shifted;

    // Shared decode used by both the FSM and the datapath. The one-hot strobe
    // pattern is gated by an explicit range check so that manual addresses
    // beyond the last frame never select a strobe bit.
    always_comb begin
        w_idleOrDone  = (r_state == ST_IDLE) || (r_state == ST_DONE);
        w_startLoad   = w_idleOrDone && start && mode_auto;
        w_manual      = (r_state == ST_IDLE) && !mode_auto;
        w_accept      = (r_state == ST_SHIFT) && din_valid;
        w_lastBeat    = w_accept && (r_beatCount == BEAT_W'(BEATS - 1));
        w_strobeEnd   = (r_strobeTimer == TIMER_W'(STROBE_LEN - 1));
        w_lastFrame   = (int'(r_frameAddr) == NUM_FRAMES - 1);
        w_addrInRange = (int'(r_frameAddr) < NUM_FRAMES);
        w_addrOneHot  = w_addrInRange ? (NUM_FRAMES'(1) << r_frameAddr) : '0;
        w_shifted     = {din, r_frameData[FRAME_W-1:SHIFT_WIDTH]};
    end

    // State register for the auto-load sequencer. Reset is synchronous, so a
    // reset sampled mid-load drops straight back to idle on that same edge.
    always_ff @(posedge config_clk) begin
        if (!config_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and status decode. A frame is shifted in, its strobe is held
    // for STROBE_LEN cycles, and one quiet gap cycle separates it from the
    // next frame. mode_auto only matters while idle or done, so toggling it
    // during a load has no effect until the load has finished.
    always_comb begin
        w_nextState = r_state;
        din_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_startLoad) begin
                    w_nextState = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                din_ready = 1'b1;
                busy      = 1'b1;
                if (w_lastBeat) begin
                    w_nextState = ST_STROBE;
                end
            end
            ST_STROBE: begin
                busy = 1'b1;
                if (w_strobeEnd) begin
                    w_nextState = ST_GAP;
                end
            end
            ST_GAP: begin
                busy        = 1'b1;
                w_nextState = w_lastFrame ? ST_DONE : ST_SHIFT;
            end
            ST_DONE: begin
                done = 1'b1;
                if (w_startLoad) begin
                    w_nextState = ST_SHIFT;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Datapath registers. The strobe register defaults to zero every cycle and
    // is only loaded with a one-hot pattern when a frame completes, while its
    // STROBE_LEN window is still running, or from a manual strobe request.
    // That keeps frame_strobe straight from flops and never more than one hot.
    // Manual controls act only in idle with mode_auto low.
    always_ff @(posedge config_clk) begin
        if (!config_rst_n) begin
            r_frameData   <= '0;
            r_frameStrobe <= '0;
            r_frameAddr   <= '0;
            r_beatCount   <= '0;
            r_strobeTimer <= '0;
            r_overrun     <= 1'b0;
        end else begin
            r_frameStrobe <= '0;
            if (w_startLoad) begin
                r_frameAddr   <= '0;
                r_beatCount   <= '0;
                r_strobeTimer <= '0;
                r_overrun     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (mode_auto && din_valid) begin
                            r_overrun <= 1'b1;
                        end
                        if (w_manual) begin
                            if (man_shift) begin
                                r_frameData <= w_shifted;
                            end
                            if (man_strobe) begin
                                r_frameStrobe <= w_addrOneHot;
                            end
                            if (man_addr_reset) begin
                                r_frameAddr <= '0;
                            end else if (man_addr_incr) begin
                                r_frameAddr <= r_frameAddr + 1'b1;
                            end
                        end
                    end
                    ST_SHIFT: begin
                        if (w_accept) begin
                            r_frameData <= w_shifted;
                            if (w_lastBeat) begin
                                r_beatCount   <= '0;
                                r_strobeTimer <= '0;
                                r_frameStrobe <= w_addrOneHot;
                            end else begin
                                r_beatCount <= r_beatCount + 1'b1;
                            end
                        end
                    end
                    ST_STROBE: begin
                        if (w_strobeEnd) begin
                            r_strobeTimer <= '0;
                        end else begin
                            r_strobeTimer <= r_strobeTimer + 1'b1;
                            r_frameStrobe <= w_addrOneHot;
                        end
                    end
                    ST_GAP: begin
                        if (!w_lastFrame) begin
                            r_frameAddr <= r_frameAddr + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign frame_data   = r_frameData;
    assign frame_strobe = r_frameStrobe;
    assign frame_addr   = r_frameAddr;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_fpga_config_loader.sv
// ---------------------------------------------------------------------------
// tb_fpga_config_loader
//
// Purpose:
//   Self-checking bench for fpga_config_loader with default parameters.
//   A behavioural model of the loader tracks load progress (frame index,
//   beats received, cycles left in the post-frame pause) and predicts every
//   output; a compare process checks the DUT against it on every falling
//   edge. Directed literal checks pin the model at key points.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_fpga_config_loader;

    localparam int FRAME_W     = 96;
    localparam int NUM_FRAMES  = 216;
    localparam int BEATS       = 12;
    localparam int ADDR_W      = 8;
    localparam int ADDR_SPAN   = 256;
    localparam int SHIFT_WIDTH = 8;
    localparam int STROBE_LEN  = 2;

    logic                   clock;
    logic                   resetN;
    logic                   modeAuto;
    logic                   startIn;
    logic [SHIFT_WIDTH-1:0] din;
    logic                   dinValid;
    logic                   dinReady;
    logic                   manShift;
    logic                   manAddrReset;
    logic                   manAddrIncr;
    logic                   manStrobe;
    logic [FRAME_W-1:0]     frameData;
    logic [NUM_FRAMES-1:0]  frameStrobe;
    logic [ADDR_W-1:0]      frameAddr;
    logic                   busy;
    logic                   done;
    logic                   overrun;

    int passCount    = 0;
    int checkCount   = 0;
    int strobeCycles = 0;
    bit compareOn    = 1'b0;

    logic [FRAME_W-1:0] mData      = '0;
    int                 mAddr      = 0;
    int                 mBeats     = 0;
    int                 mPause     = 0;
    int                 mStrobeIdx = -1;
    bit                 mLoading   = 1'b0;
    bit                 mDone      = 1'b0;
    bit                 mOverrun   = 1'b0;

    fpga_config_loader dut (
        .config_clk     (clock),
        .config_rst_n   (resetN),
        .mode_auto      (modeAuto),
        .start          (startIn),
        .din            (din),
        .din_valid      (dinValid),
        .din_ready      (dinReady),
        .man_shift      (manShift),
        .man_addr_reset (manAddrReset),
        .man_addr_incr  (manAddrIncr),
        .man_strobe     (manStrobe),
        .frame_data     (frameData),
        .frame_strobe   (frameStrobe),
        .frame_addr     (frameAddr),
        .busy           (busy),
        .done           (done),
        .overrun        (overrun)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // New beat enters at the top, everything else moves down one beat.
    function automatic logic [FRAME_W-1:0] shiftIn(input logic [FRAME_W-1:0] cur,
                                                   input logic [SHIFT_WIDTH-1:0] d);
        return (cur >> SHIFT_WIDTH) | (FRAME_W'(d) << (FRAME_W - SHIFT_WIDTH));
    endfunction

    function automatic logic [255:0] strobeVec(input int idx);
        logic [255:0] v;
        v = '0;
        if (idx >= 0) begin
            v = 256'd1 << idx;
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act,
                               input logic [255:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input bit mAuto, input bit st, input bit dv,
                                 input logic [SHIFT_WIDTH-1:0] d, input bit ms,
                                 input bit mar, input bit mai, input bit mst);
        modeAuto     = mAuto;
        startIn      = st;
        dinValid     = dv;
        din          = d;
        manShift     = ms;
        manAddrReset = mar;
        manAddrIncr  = mai;
        manStrobe    = mst;
        tick();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "Data"},   256'(frameData),   256'(0));
        checkOutput({tag, "Strobe"}, 256'(frameStrobe), 256'(0));
        checkOutput({tag, "Addr"},   256'(frameAddr),   256'(0));
        checkOutput({tag, "Ready"},  256'(dinReady),    256'(0));
        checkOutput({tag, "Busy"},   256'(busy),        256'(0));
        checkOutput({tag, "Done"},   256'(done),        256'(0));
        checkOutput({tag, "Ovr"},    256'(overrun),     256'(0));
    endtask

    // Behavioural model. Outside a load it applies the idle rules (start,
    // overrun, manual controls). During a load it counts beats per frame;
    // after the last beat it enters a pause of STROBE_LEN strobe cycles plus
    // one quiet cycle, then moves to the next frame or finishes.
    always @(posedge clock) begin
        if (!resetN) begin
            mData      = '0;
            mAddr      = 0;
            mBeats     = 0;
            mPause     = 0;
            mStrobeIdx = -1;
            mLoading   = 1'b0;
            mDone      = 1'b0;
            mOverrun   = 1'b0;
        end else if (!mLoading) begin
            mStrobeIdx = -1;
            if (startIn && modeAuto) begin
                mLoading = 1'b1;
                mDone    = 1'b0;
                mAddr    = 0;
                mBeats   = 0;
                mPause   = 0;
                mOverrun = 1'b0;
            end else begin
                if (modeAuto && dinValid) begin
                    mOverrun = 1'b1;
                end
                if (!modeAuto && !mDone) begin
                    if (manShift) begin
                        mData = shiftIn(mData, din);
                    end
                    if (manStrobe && mAddr < NUM_FRAMES) begin
                        mStrobeIdx = mAddr;
                    end
                    if (manAddrReset) begin
                        mAddr = 0;
                    end else if (manAddrIncr) begin
                        mAddr = (mAddr + 1) % ADDR_SPAN;
                    end
                end
            end
        end else if (mPause > 0) begin
            mPause = mPause - 1;
            if (mPause == 0) begin
                mStrobeIdx = -1;
                if (mAddr == NUM_FRAMES - 1) begin
                    mLoading = 1'b0;
                    mDone    = 1'b1;
                end else begin
                    mAddr = mAddr + 1;
                end
            end else begin
                mStrobeIdx = (mPause >= 2) ? mAddr : -1;
            end
        end else if (dinValid) begin
            mData  = shiftIn(mData, din);
            mBeats = mBeats + 1;
            if (mBeats == BEATS) begin
                mBeats     = 0;
                mPause     = STROBE_LEN + 1;
                mStrobeIdx = mAddr;
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    // Also counts strobe-high cycles for the full-load pin check.
    always @(negedge clock) begin
        if (compareOn) begin
            checkOutput("cmpData",   256'(frameData),   256'(mData));
            checkOutput("cmpStrobe", 256'(frameStrobe), strobeVec(mStrobeIdx));
            checkOutput("cmpAddr",   256'(frameAddr),   256'(mAddr));
            checkOutput("cmpReady",  256'(dinReady),    256'(mLoading && mPause == 0));
            checkOutput("cmpBusy",   256'(busy),        256'(mLoading));
            checkOutput("cmpDone",   256'(done),        256'(mDone));
            checkOutput("cmpOvr",    256'(overrun),     256'(mOverrun));
            if (frameStrobe != '0) begin
                strobeCycles++;
            end
        end
    end

    // Directed and randomized stimulus sequence.
    initial begin
        int cyc;
        resetN       = 1'b0;
        modeAuto     = 1'b0;
        startIn      = 1'b0;
        din          = '0;
        dinValid     = 1'b0;
        manShift     = 1'b0;
        manAddrReset = 1'b0;
        manAddrIncr  = 1'b0;
        manStrobe    = 1'b0;
        tick();
        compareOn = 1'b1;
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 0);
        checkResetValues("rst");
        resetN = 1'b1;

        $display("[TB] first frame, back-to-back beats");
        strobeCycles = 0;
        applyStimulus(1, 1, 0, 8'h00, 0, 0, 0, 0);
        checkOutput("startBusy",  256'(busy),     256'(1));
        checkOutput("startReady", 256'(dinReady), 256'(1));
        for (int b = 1; b <= BEATS; b++) begin
            applyStimulus(1, 0, 1, 8'(b), 0, 0, 0, 0);
        end
        checkOutput("frame0Data",  256'(frameData),
                    256'(96'h0C0B0A09_08070605_04030201));
        checkOutput("frame0Strb1", 256'(frameStrobe), 256'(1));
        checkOutput("frame0Rdy",   256'(dinReady),    256'(0));
        applyStimulus(1, 0, 0, 8'h00, 0, 0, 0, 0);
        checkOutput("frame0Strb2", 256'(frameStrobe), 256'(1));
        applyStimulus(1, 0, 0, 8'h00, 0, 0, 0, 0);
        checkOutput("frame0Gap",   256'(frameStrobe), 256'(0));
        checkOutput("frame0GapAd", 256'(frameAddr),   256'(0));
        applyStimulus(1, 0, 0, 8'h00, 0, 0, 0, 0);
        checkOutput("frame1Addr",  256'(frameAddr),   256'(1));
        checkOutput("frame1Rdy",   256'(dinReady),    256'(1));

        $display("[TB] remaining frames, random gaps and mode toggles");
        cyc = 0;
        while (!done && cyc < 20000) begin
            applyStimulus(1'($urandom_range(0, 1)), 0, ($urandom_range(0, 3) != 0),
                          8'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            cyc++;
        end
        checkOutput("loadDone",     256'(done),         256'(1));
        checkOutput("loadBusy",     256'(busy),         256'(0));
        checkOutput("loadReady",    256'(dinReady),     256'(0));
        checkOutput("strobeCycles", 256'(strobeCycles), 256'(NUM_FRAMES * STROBE_LEN));

        $display("[TB] overrun in done, then restart");
        applyStimulus(1, 0, 1, 8'hA5, 0, 0, 0, 0);
        checkOutput("ovrSet",    256'(overrun),   256'(1));
        applyStimulus(1, 1, 0, 8'h00, 0, 0, 0, 0);
        checkOutput("ovrClear",  256'(overrun),   256'(0));
        checkOutput("restartAd", 256'(frameAddr), 256'(0));
        checkOutput("restartDn", 256'(done),      256'(0));

        $display("[TB] reset during strobe of frame 7");
        cyc = 0;
        while (frameStrobe[7] !== 1'b1 && cyc < 2000) begin
            applyStimulus(1, 0, 1, 8'($urandom), 0, 0, 0, 0);
            cyc++;
        end
        checkOutput("frame7Strobe", 256'(frameStrobe), strobeVec(7));
        resetN = 1'b0;
        applyStimulus(1, 0, 0, 8'h00, 0, 0, 0, 0);
        checkResetValues("midRst");
        resetN = 1'b1;

        $display("[TB] manual control");
        applyStimulus(0, 0, 0, 8'h00, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 0, 0, 1, 0);
        end
        checkOutput("manAddr5", 256'(frameAddr), 256'(5));
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 1);
        checkOutput("manStrobe5", 256'(frameStrobe), strobeVec(5));
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 0);
        checkOutput("manStrobeOff", 256'(frameStrobe), 256'(0));
        applyStimulus(0, 0, 0, 8'h00, 0, 1, 1, 0);
        checkOutput("manRstWins", 256'(frameAddr), 256'(0));
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 1'($urandom_range(0, 1)), 8'($urandom),
                          1'($urandom_range(0, 1)), 0, 0, 0);
        end
        for (int i = 0; i < 220; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 0, 0, 1, 0);
        end
        checkOutput("manAddr220", 256'(frameAddr), 256'(220));
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 1);
        checkOutput("manStrobeOOR", 256'(frameStrobe), 256'(0));
        for (int i = 0; i < 36; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 0, 0, 1, 0);
        end
        checkOutput("manAddrWrap", 256'(frameAddr), 256'(0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 8'h3C, 1, 0, 1, 1);
        end
        checkOutput("autoIgnAddr",   256'(frameAddr),   256'(0));
        checkOutput("autoIgnStrobe", 256'(frameStrobe), 256'(0));
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 0);

        compareOn = 1'b0;
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fpga_config_loader.md
FPGA_CONFIG_LOADER -- requirements
Module: fpga_config_loader

Interface
REQ-001 Param NUM_ROWS, default 3: fabric rows.
REQ-002 Param NUM_COLS, default 6: fabric columns.
REQ-003 Param FRAME_BITS_PER_ROW, default 32: frame bits per row.
REQ-004 Param MAX_FRAMES_PER_COL, default 36: frames per column.
REQ-005 Param SHIFT_WIDTH, default 8: bits accepted per beat; legal values 1, 2, 4 or 8; FRAME_W SHALL be a multiple of SHIFT_WIDTH.
REQ-006 Param STROBE_LEN, default 2: strobe high cycles, range 1..15.
REQ-007 Derived: FRAME_W = NUM_ROWS*FRAME_BITS_PER_ROW; NUM_FRAMES = NUM_COLS*MAX_FRAMES_PER_COL; BEATS = FRAME_W/SHIFT_WIDTH; ADDR_W = max(1, clog2(NUM_FRAMES)).
REQ-008 config_clk  in  1  sole clock; all state on rising edge.
REQ-009 config_rst_n  in  1  reset, synchronous, active-low.
REQ-010 mode_auto  in  1  1 = auto streaming load, 0 = manual legacy control.
REQ-011 start  in  1  auto mode: begin full load from frame 0.
REQ-012 din  in  SHIFT_WIDTH  bitstream beat.
REQ-013 din_valid  in  1  beat present.
REQ-014 din_ready  out  1  beat accepted when din_valid & din_ready.
REQ-015 man_shift, man_addr_reset, man_addr_incr, man_strobe  in  1 each  manual controls.
REQ-016 frame_data  out  FRAME_W  frame data register.
REQ-017 frame_strobe  out  NUM_FRAMES  one-hot frame write strobes, registered.
REQ-018 frame_addr  out  ADDR_W  current frame address.
REQ-019 busy, done, overrun  out  1 each  status.

Function
REQ-020 Shift: each shift event SHALL load frame_data <= {din, frame_data[FRAME_W-1:SHIFT_WIDTH]}; din enters at MSB.
REQ-021 Auto FSM states IDLE, SHIFT, STROBE, GAP, DONE; busy=1 in SHIFT/STROBE/GAP only.
REQ-022 IDLE/DONE: start & mode_auto -> SHIFT, frame_addr=0, beat count=0, overrun cleared; start ignored in other states.
REQ-023 SHIFT: din_ready=1; each accepted beat shifts and increments beat count; accepted beat BEATS-1 -> STROBE next cycle, count cleared.
REQ-024 STROBE: din_ready=0; frame_strobe[frame_addr] high exactly STROBE_LEN cycles starting the cycle after the last beat; all other bits 0; then GAP.
REQ-025 GAP: one cycle, all strobes 0; if frame_addr==NUM_FRAMES-1 -> DONE, else frame_addr+1 -> SHIFT.
REQ-026 DONE: done=1 until next start or reset; din_ready=0.
REQ-027 din_valid=1 in IDLE or DONE while mode_auto=1 SHALL set sticky overrun; cleared only by start or reset.
REQ-028 mode_auto sampled only in IDLE/DONE; changes while busy ignored until load completes.
REQ-029 Manual mode (mode_auto=0, state IDLE): din_ready=0; man_shift shifts din per cycle (din_valid ignored); man_addr_reset clears frame_addr, else man_addr_incr increments (reset wins); frame_addr wraps modulo 2^ADDR_W.
REQ-030 Manual strobe: frame_strobe[frame_addr] registered from man_strobe, one cycle latency; frame_addr >= NUM_FRAMES drives no strobe.
REQ-031 Manual controls SHALL be ignored while mode_auto=1 or busy.
REQ-032 frame_strobe SHALL have at most one bit set in any cycle and be driven directly from flops.

Reset
REQ-033 config_rst_n=0 at a clock edge: state IDLE, frame_data=0, frame_strobe=0, frame_addr=0, beat count=0, strobe timer=0, din_ready=0, busy=0, done=0, overrun=0.
REQ-034 Reset mid-load SHALL abort immediately; no strobe asserted the cycle after reset sampled low.

Verification
REQ-035 Defaults, auto, start, 12 beats 0x01..0x0C back-to-back -> frame_data=0x0C0B..01, frame_strobe[0] high 2 cycles starting cycle after beat 12, frame_addr=1 after GAP.
REQ-036 Full auto load of 216 frames with random din_valid gaps -> strobes 0..215 in order, each exactly 2 cycles, done=1, busy=0, din_ready=0.
REQ-037 din_valid=1 in DONE -> overrun=1; next start -> overrun=0, frame_addr=0.
REQ-038 Manual: man_addr_reset, 5x man_addr_incr, man_strobe 1 cycle -> frame_strobe[5] high one cycle, one cycle later; man_addr_reset+man_addr_incr same cycle -> frame_addr=0.
REQ-039 Manual: frame_addr driven to 220 then man_strobe -> frame_strobe all zero.
REQ-040 config_rst_n low during STROBE of frame 7 -> next cycle all outputs at reset values; mode_auto toggled while busy -> load unaffected.
